// File: rtl/cvrt_gry_bin_pipe.sv
// Pipelined Gray-to-binary decoder with valid/ready flow control and a
// single-step checker that flags non-adjacent Gray transitions.
module cvrt_gry_bin_pipe #(
    parameter int DATA_WIDTH = 4,
    parameter int STAGES     = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic [DATA_WIDTH-1:0] i_gry,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_bin,
    output logic                  o_step_err,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam int BASE_BITS = DATA_WIDTH / STAGES;

    // Highest bit resolved by stage s; bits are resolved MSB-first.
    function automatic int stage_hi(input int s);
        return DATA_WIDTH - 1 - s * BASE_BITS;
    endfunction

    // Lowest bit resolved by stage s; the last stage absorbs the remainder.
    function automatic int stage_lo(input int s);
        return (s == STAGES - 1) ? 0 : stage_hi(s) - BASE_BITS + 1;
    endfunction

    // Bits above hi are already binary, bits in [hi:lo] are turned into binary,
    // bits below lo stay Gray for the following stages.
    function automatic logic [DATA_WIDTH-1:0] resolve(
        input logic [DATA_WIDTH-1:0] word,
        input int                    hi,
        input int                    lo
    );
        logic [DATA_WIDTH-1:0] res;
        res = word;
        for (int k = DATA_WIDTH - 2; k >= 0; k--) begin
            if (k <= hi && k >= lo) begin
                res[k] = res[k+1] ^ res[k];
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] stage_data [STAGES];
    logic [STAGES-1:0]     stage_vld;
    logic [STAGES-1:0]     stage_err;

    logic [DATA_WIDTH-1:0] up_data    [STAGES];
    logic [DATA_WIDTH-1:0] next_data  [STAGES];
    logic [STAGES-1:0]     up_vld;
    logic [STAGES-1:0]     up_err;
    logic [STAGES-1:0]     advance;

    logic [DATA_WIDTH-1:0] prev_gry;
    logic                  has_prev;
    logic [DATA_WIDTH-1:0] diff;
    logic                  multi_bit;
    logic                  chk_err;
    logic                  in_xfer;

    // A stage may load when it is empty or everything downstream moves on,
    // so any bubble upstream of a stall is collapsed.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        logic down;
        down    = i_ready;
        advance = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            advance[s] = ~stage_vld[s] | down;
            down       = advance[s];
        end
    end

    assign o_ready = advance[0];
    assign in_xfer = i_valid & o_ready;

    // More than one differing bit <=> clearing the lowest set bit leaves something.
    assign diff      = i_gry ^ prev_gry;
    assign multi_bit = |(diff & (diff - DATA_WIDTH'(1)));
    assign chk_err   = has_prev & ~i_clr & multi_bit;

    always_comb begin
        up_data[0] = i_gry;
        up_vld[0]  = i_valid;
        up_err[0]  = chk_err;
        for (int s = 1; s < STAGES; s++) begin
            up_data[s] = stage_data[s-1];
            up_vld[s]  = stage_vld[s-1];
            up_err[s]  = stage_err[s-1];
        end
        for (int s = 0; s < STAGES; s++) begin
            next_data[s] = resolve(up_data[s], stage_hi(s), stage_lo(s));
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            // NOTE: the data registers are reset too, because o_bin must read zero out of reset.
            for (int s = 0; s < STAGES; s++) begin
                stage_data[s] <= '0;
            end
            stage_vld <= '0;
            stage_err <= '0;
            prev_gry  <= '0;
            has_prev  <= 1'b0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (advance[s]) begin
                    stage_vld[s] <= up_vld[s];
                    if (up_vld[s]) begin
                        stage_data[s] <= next_data[s];
                        stage_err[s]  <= up_err[s];
                    end
                end
            end

            // An accepted code always becomes the new reference, even under i_clr.
            if (in_xfer) begin
                prev_gry <= i_gry;
                has_prev <= 1'b1;
            end else if (i_clr) begin
                has_prev <= 1'b0;
            end
        end
    end

    assign o_valid    = stage_vld[STAGES-1];
    assign o_bin      = stage_data[STAGES-1];
    assign o_step_err = stage_err[STAGES-1];

endmodule

// File: tb/tb_cvrt_gry_bin_pipe.sv
// Drives three decoders (STAGES = 1, 2, 4) with the same directed stimulus and
// checks each against a queue-based reference model of Gray decoding and step checking.
module tb_cvrt_gry_bin_pipe;

    typedef struct {
        logic [3:0] bin;
        logic       err;
        logic       lit;
        logic [3:0] lbin;
        logic       lerr;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] gry = '0;
    logic [2:0] vld_v = '0;
    logic [2:0] clr_v;
    logic [2:0] rdy_v;
    logic [2:0] oval_v;
    logic [2:0] err_v;
    logic [3:0] bin_a [3];
    logic       dn_ready = 1'b1;

    logic       clr_req = 1'b0;
    logic       lit_on = 1'b0;
    logic [3:0] lit_bin = '0;
    logic       lit_err = 1'b0;
    logic       lat_mode = 1'b0;
    logic       bp_on = 1'b0;
    logic [1:0] bp_idx = '0;
    logic [3:0] bp_pat = 4'b1001;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    exp_t       exp_q [3][$];
    logic [3:0] prev [3];
    logic [2:0] has_prev = '0;
    logic [2:0] hold_arm = '0;
    logic [3:0] h_bin [3];
    logic [2:0] h_err = '0;

    always #5 clk = ~clk;

    assign clr_v = {3{clr_req}} & vld_v;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        cvrt_gry_bin_pipe #(
            .DATA_WIDTH(4),
            .STAGES    ((k == 0) ? 1 : ((k == 1) ? 2 : 4))
        ) u_dut (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_clr     (clr_v[k]),
            .i_gry     (gry),
            .i_valid   (vld_v[k]),
            .o_ready   (rdy_v[k]),
            .o_bin     (bin_a[k]),
            .o_step_err(err_v[k]),
            .o_valid   (oval_v[k]),
            .i_ready   (dn_ready)
        );
    end

    function automatic int stg(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    function automatic logic [3:0] to_gray(input int n);
        logic [3:0] v;
        v = 4'(n);
        return v ^ (v >> 1);
    endfunction

    // Binary is the running XOR of all Gray bits at and above each position.
    function automatic logic [3:0] model_bin(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    task automatic check(input string name, input int lane, input logic [31:0] act,
                         input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s lane%0d(STAGES=%0d) t=%0t: got %0h, expected %0h",
                     name, lane, stg(lane), $time, act, req);
        end
    endtask

    // Reference model and compare process: everything is sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    exp_q[k].delete();
                    has_prev[k] = 1'b0;
                    prev[k]     = '0;
                    hold_arm[k] = 1'b0;
                end else begin
                    if (hold_arm[k]) begin
                        check("hold_valid", k, 32'(oval_v[k]), 32'd1);
                        check("hold_bin",   k, 32'(bin_a[k]),  32'(h_bin[k]));
                        check("hold_err",   k, 32'(err_v[k]),  32'(h_err[k]));
                    end
                    hold_arm[k] = oval_v[k] & ~dn_ready;
                    h_bin[k]    = bin_a[k];
                    h_err[k]    = err_v[k];

                    if (!rdy_v[k]) begin
                        check("ready_low_full",  k, 32'(exp_q[k].size()), 32'(stg(k)));
                        check("ready_low_stall", k, 32'(dn_ready), 32'd0);
                    end

                    if (oval_v[k] && dn_ready) begin
                        if (exp_q[k].size() == 0) begin
                            check("unexpected_out", k, 32'(bin_a[k]), 32'hffff_ffff);
                        end else begin
                            exp_t e;
                            e = exp_q[k].pop_front();
                            check("bin", k, 32'(bin_a[k]), 32'(e.bin));
                            check("step_err", k, 32'(err_v[k]), 32'(e.err));
                            if (e.lit) begin
                                check("lit_bin", k, 32'(bin_a[k]), 32'(e.lbin));
                                check("lit_err", k, 32'(err_v[k]), 32'(e.lerr));
                            end
                            if (lat_mode) begin
                                check("latency", k, 32'(cyc - e.cyc), 32'(stg(k)));
                            end
                        end
                    end

                    if (vld_v[k] && rdy_v[k]) begin
                        exp_t n;
                        n.bin  = model_bin(gry);
                        n.err  = has_prev[k] && !clr_v[k] && ($countones(gry ^ prev[k]) > 1);
                        n.lit  = lit_on;
                        n.lbin = lit_bin;
                        n.lerr = lit_err;
                        n.cyc  = cyc;
                        exp_q[k].push_back(n);
                        prev[k]     = gry;
                        has_prev[k] = 1'b1;
                    end else if (clr_v[k]) begin
                        has_prev[k] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_on) begin
            dn_ready = bp_pat[bp_idx];
            bp_idx   = bp_idx + 2'd1;
        end
    endtask

    // Offer one code to all three lanes; each lane drops valid once it has taken it.
    task automatic send(input logic [3:0] code, input logic clr, input logic lit,
                        input logic [3:0] lbin, input logic lerr);
        logic [2:0] acc;
        gry     = code;
        clr_req = clr;
        lit_on  = lit;
        lit_bin = lbin;
        lit_err = lerr;
        vld_v   = 3'b111;
        for (int t = 0; t < 64 && vld_v != 3'b000; t++) begin
            @(negedge clk);
            acc = vld_v & rdy_v;
            tick();
            vld_v = vld_v & ~acc;
        end
        if (vld_v != 3'b000) begin
            check("send_timeout", 0, 32'(vld_v), 32'd0);
        end
        vld_v   = '0;
        clr_req = 1'b0;
        lit_on  = 1'b0;
    endtask

    task automatic drain(input string name);
        int left;
        left = 1;
        for (int t = 0; t < 100 && left != 0; t++) begin
            tick();
            left = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
        end
        check(name, 0, 32'(left), 32'd0);
    endtask

    task automatic post_reset_checks();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_valid", k, 32'(oval_v[k]), 32'd0);
            check("rst_bin",   k, 32'(bin_a[k]),  32'd0);
            check("rst_err",   k, 32'(err_v[k]),  32'd0);
            check("rst_ready", k, 32'(rdy_v[k]),  32'd1);
        end
        tick();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        vld_v = '0;
        post_reset_checks();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        post_reset_checks();

        // Full Gray count with no backpressure, then the wrap back to zero.
        dn_ready = 1'b1;
        lat_mode = 1'b1;
        for (int n = 0; n < 16; n++) begin
            send(to_gray(n), 1'b0, 1'b0, 4'h0, 1'b0);
        end
        send(4'b1000, 1'b0, 1'b1, 4'b1111, 1'b0);
        send(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);
        drain("drain_count");
        lat_mode = 1'b0;

        // Spot decodes; each code after the first differs in several bits.
        reset_pulse();
        send(4'b0110, 1'b0, 1'b1, 4'b0100, 1'b0);
        send(4'b1000, 1'b0, 1'b1, 4'b1111, 1'b1);
        send(4'b1101, 1'b0, 1'b1, 4'b1001, 1'b1);
        send(4'b0011, 1'b0, 1'b1, 4'b0010, 1'b1);
        drain("drain_spot");

        // Illegal step, then a repeated code.
        reset_pulse();
        send(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);
        send(4'b0011, 1'b0, 1'b1, 4'b0010, 1'b1);
        send(4'b0011, 1'b0, 1'b1, 4'b0010, 1'b0);
        drain("drain_step");

        // Backpressure with i_ready cycling 1,0,0,1.
        reset_pulse();
        bp_idx = '0;
        bp_on  = 1'b1;
        for (int n = 0; n < 8; n++) begin
            send(to_gray(n), 1'b0, 1'b0, 4'h0, 1'b0);
        end
        bp_on    = 1'b0;
        dn_ready = 1'b1;
        drain("drain_bp");

        // History clear coinciding with a transfer.
        reset_pulse();
        send(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);
        send(4'b1111, 1'b1, 1'b1, 4'b1010, 1'b0);
        send(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1);
        drain("drain_clr");

        // Reset while two codes are offered into a stalled pipeline.
        dn_ready = 1'b0;
        gry      = 4'b0101;
        vld_v    = 3'b111;
        tick();
        gry = 4'b1010;
        tick();
        reset_pulse();
        dn_ready = 1'b1;
        send(4'b0011, 1'b0, 1'b1, 4'b0010, 1'b0);
        drain("drain_rst");

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cvrt_gry_bin_pipe.md
Name: cvrt_gry_bin_pipe

Overview:
Pipelined Gray-to-binary decoder with valid/ready handshake. It is the receive-side counterpart of the binary-to-Gray converter, used where Gray-coded pointers or counters arrive from another clock domain. It also checks each accepted code against the previous one and flags any transition that is not a legal single-bit Gray step.

Parameters:
DATA_WIDTH, 4, width of the Gray input and binary output (legal range 2..32).
STAGES, 2, number of pipeline register stages (legal range 1..DATA_WIDTH); bits are resolved MSB-first, split evenly across stages, and the last stage takes the remainder.

Ports:
i_clk  input  1  clock; all logic is on the rising edge.
i_rst  input  1  synchronous reset, active-high.
i_clr  input  1  clears step-checker history (first-code state); pipeline contents are unaffected.
i_gry  input  DATA_WIDTH  Gray code in.
i_valid  input  1  i_gry is valid.
o_ready  output  1  block can accept i_gry this cycle.
o_bin  output  DATA_WIDTH  decoded binary value.
o_step_err  output  1  qualifies o_bin: this code's Hamming distance from the previously accepted code is greater than 1.
o_valid  output  1  o_bin and o_step_err are valid.
i_ready  input  1  downstream accepts the output.

Behaviour:
- Decode: bin[W-1] = gry[W-1]; bin[k] = bin[k+1] XOR gry[k] for k = W-2 down to 0.
  - Stage s computes its slice of bin bits from the previous stage's partial result.
  - Stage s carries the unresolved Gray bits forward.
- Transfer rules:
  - Input transfer = i_valid & o_ready.
  - Output transfer = o_valid & i_ready.
- Pipeline control:
  - Each stage has a valid bit.
  - A stage loads when it is empty or the stage downstream of it advances.
  - o_ready = ~valid[STAGES-1] | i_ready, or any bubble upstream of the stall (bubble-collapsing).
  - Simpler global stall is acceptable: o_ready = ~o_valid | i_ready.
- Latency:
  - STAGES cycles from input transfer to o_valid, with i_ready held high.
  - Throughput is 1 code per cycle.
- Output hold: while o_valid = 1 and i_ready = 0, o_bin, o_step_err and o_valid hold stable. No data is dropped or duplicated.
- Step checker, evaluated at input transfer:
  - dist = popcount(i_gry XOR prev_gry).
  - err = has_prev & (dist > 1).
  - dist = 0 (repeated code) is legal and gives err = 0.
  - Then prev_gry <= i_gry and has_prev <= 1.
  - err travels down the pipeline with its data and appears on o_step_err alongside o_bin.
- Wrap-around: the transition from max code (e.g. 4'b1000) to 4'b0000 is distance 1 and is legal.
- i_clr:
  - Sets has_prev <= 0; the next accepted code has err = 0.
  - If i_clr coincides with an input transfer, the clear wins for history, the current code is checked with has_prev = 0, and then prev_gry <= i_gry with has_prev <= 1.
- Reset (i_rst = 1), which overrides everything including mid-transfer:
  - All stage valid bits = 0, so o_valid = 0.
  - o_bin = 0, o_step_err = 0.
  - prev_gry = 0, has_prev = 0.
  - o_ready = 1 in the first cycle after reset deasserts.
  - Data in flight during reset is discarded.
- Simultaneous input and output transfer on a full pipeline is allowed and sustains full throughput.

Test Plan:
1. Reset, i_ready = 1, STAGES = 2; drive i_gry = Gray(0..15), one per cycle, i_valid = 1 -> o_bin = 0..15 in order, starting 2 cycles after the first transfer; o_step_err = 0 throughout; then drive 4'b1000 -> 4'b0000 (wrap) -> o_bin = 15, 0 with no error.
2. Spot decodes: 4'b0110 -> 4'b0100; 4'b1000 -> 4'b1111; 4'b1101 -> 4'b1001; 4'b0011 -> 4'b0010.
3. Step error: after reset, send 4'b0000 then 4'b0011 -> second output is o_bin = 4'b0010 with o_step_err = 1; then 4'b0011 repeated -> o_step_err = 0.
4. Backpressure: stream Gray(0..7) with i_ready toggled 1,0,0,1,... -> o_bin stable while stalled; the sequence 0..7 is received exactly once each; o_ready = 0 only when the pipeline is full and stalled.
5. i_clr: send 4'b0000; pulse i_clr together with 4'b1111 -> o_step_err = 0; then send 4'b0000 -> o_step_err = 1.
6. Reset mid-stream: with 2 codes in flight, assert i_rst for 1 cycle -> o_valid = 0, o_bin = 0 the next cycle; neither in-flight code ever appears; o_ready = 1; the first code after reset gives o_step_err = 0. Repeat scenarios 1 and 4 with STAGES = 1 and STAGES = 4.
